// File: rtl/acc_pkg.sv
// Shared types and defaults for the quad-operand accumulator.
// Holds the controller state encoding, default sizing constants and the
// helper that sizes the operand counter.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } acc_state_t;

   localparam int OP_W_DEF  = 4;
   localparam int N_OPS_DEF = 4;
   localparam int SUM_W_DEF = 6;

   // Counter must represent 0..N_OPS, so one bit above clog2(N_OPS).
   function automatic int cnt_w(input int n_ops);
      return $clog2(n_ops) + 1;
   endfunction

endpackage

// File: rtl/acc_add_stage.sv
// Single adder of the accumulator: acc + zero-extended operand.
// The sum wraps modulo 2^SUM_W; the carry out of bit SUM_W-1 is exported
// so the optional overflow tracking can observe it.
module acc_add_stage #(
   parameter int OP_W  = 4,
   parameter int SUM_W = 6
) (
   input  logic [SUM_W-1:0] acc,
   input  logic [OP_W-1:0]  op,
   output logic [SUM_W-1:0] sum,
   output logic             carry
);

   logic [SUM_W:0] full;

   // Operand is zero-extended to SUM_W+1 bits so the top bit is the carry.
   always_comb begin
      full  = {1'b0, acc} + {{(SUM_W + 1 - OP_W){1'b0}}, op};
      sum   = full[SUM_W-1:0];
      carry = full[SUM_W];
   end

endmodule

// File: rtl/quad_operand_accumulator.sv
// Sequential multi-operand accumulator.
// Collects N_OPS unsigned operands over a valid/ready input, reusing one
// registered add stage, and presents the wrapped total on a valid/ready
// output held stable under backpressure.
// Optional feature macro: ACC_OVF_EN adds the out_ovf port, a sticky flag
// recording any carry out of the accumulator within a batch.
module quad_operand_accumulator
   import acc_pkg::*;
#(
   parameter int OP_W  = OP_W_DEF,
   parameter int N_OPS = N_OPS_DEF,
   parameter int SUM_W = SUM_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum
`ifdef ACC_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int CNT_W = cnt_w(N_OPS);

   acc_state_t       state;
   logic [SUM_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] add_a;
   logic [SUM_W-1:0] add_sum;
   logic             accept;
   logic             last_op;

`ifdef ACC_OVF_EN
   logic             add_carry;
   logic             ovf_flag;
`else
   logic             carry_unused;
`endif

   // Accept decode; the first operand of a batch starts from zero.
   always_comb begin
      in_ready = (state != HOLD);
      accept   = in_valid && in_ready;
      last_op  = (cnt == CNT_W'(N_OPS - 1));
      add_a    = (state == IDLE) ? '0 : acc;
   end

   acc_add_stage #(
      .OP_W  (OP_W),
      .SUM_W (SUM_W)
   ) u_add (
      .acc   (add_a),
      .op    (in_op),
      .sum   (add_sum),
`ifdef ACC_OVF_EN
      .carry (add_carry)
`else
      .carry (carry_unused)
`endif
   );

   // Batch controller: accumulate, publish result, wait for consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         out_sum   <= '0;
         out_valid <= 1'b0;
`ifdef ACC_OVF_EN
         ovf_flag  <= 1'b0;
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= add_sum;
                  cnt   <= CNT_W'(1);
                  state <= ACCUM;
`ifdef ACC_OVF_EN
                  ovf_flag <= add_carry;
`endif
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc <= add_sum;
                  cnt <= cnt + CNT_W'(1);
`ifdef ACC_OVF_EN
                  ovf_flag <= ovf_flag | add_carry;
`endif
                  if (last_op) begin
                     out_sum   <= add_sum;
                     out_valid <= 1'b1;
                     state     <= HOLD;
`ifdef ACC_OVF_EN
                     out_ovf   <= ovf_flag | add_carry;
`endif
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  state     <= IDLE;
`ifdef ACC_OVF_EN
                  out_ovf   <= 1'b0;
`endif
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quad_operand_accumulator.sv
// Bench for quad_operand_accumulator: a default (N_OPS=4) instance and an
// N_OPS=8 instance, each with a model that pushes expected batch results
// to a queue as operands are accepted; output monitors pop and compare.
module tb_quad_operand_accumulator;

   typedef struct {
      logic [5:0] sum;
      logic       ovf;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [3:0] a_in_op, b_in_op;
   logic [5:0] a_out_sum, b_out_sum;
`ifdef ACC_OVF_EN
   logic       a_out_ovf, b_out_ovf;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   int   a_xfers = 0;
   res_t qa[$];
   res_t qb[$];

   int         m_cnt  [2];
   logic [5:0] m_acc  [2];
   logic       m_flag [2];
   int         m_nops [2];

   always #5 clk = ~clk;

   quad_operand_accumulator u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_op     (a_in_op),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_sum   (a_out_sum)
`ifdef ACC_OVF_EN
      ,
      .out_ovf   (a_out_ovf)
`endif
   );

   quad_operand_accumulator #(
      .OP_W  (4),
      .N_OPS (8),
      .SUM_W (6)
   ) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_op     (b_in_op),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_sum   (b_out_sum)
`ifdef ACC_OVF_EN
      ,
      .out_ovf   (b_out_ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference behaviour of one accepted operand.
   task automatic model_accept(input int d, input logic [3:0] op);
      logic [6:0] s;
      if (m_cnt[d] == 0) m_flag[d] = 1'b0;
      s         = {1'b0, m_acc[d]} + {3'b000, op};
      m_flag[d] = m_flag[d] | s[6];
      m_acc[d]  = s[5:0];
      m_cnt[d]++;
      if (m_cnt[d] == m_nops[d]) begin
         if (d == 0) qa.push_back('{m_acc[d], m_flag[d]});
         else        qb.push_back('{m_acc[d], m_flag[d]});
         m_cnt[d] = 0;
         m_acc[d] = '0;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d]  = 0;
         m_acc[d]  = '0;
         m_flag[d] = 1'b0;
      end
   endtask

   // Offer one operand until accepted; returns at posedge+1 after acceptance.
   task automatic send(input int d, input logic [3:0] op);
      logic rdy;
      for (int i = 0; i < 40; i++) begin
         if (d == 0) begin a_in_valid = 1'b1; a_in_op = op; end
         else        begin b_in_valid = 1'b1; b_in_op = op; end
         @(negedge clk);
         rdy = (d == 0) ? a_in_ready : b_in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            model_accept(d, op);
            if (d == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 0, 1);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitors: a transfer is committed at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         a_xfers++;
         if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
         else begin
            res_t r;
            r = qa.pop_front();
            chk("a_sum", a_out_sum, r.sum);
`ifdef ACC_OVF_EN
            chk("a_ovf", a_out_ovf, r.ovf);
`endif
         end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
         else begin
            res_t r;
            r = qb.pop_front();
            chk("b_sum", b_out_sum, r.sum);
`ifdef ACC_OVF_EN
            chk("b_ovf", b_out_ovf, r.ovf);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      logic [3:0] t1 [4];
      m_nops[0] = 4;
      m_nops[1] = 8;
      model_reset();
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_op = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_op = '0; b_out_ready = 1'b1;
      tick();
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_out_sum", a_out_sum, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel_a_in_ready", a_in_ready, 1);
      chk("rel_b_in_ready", b_in_ready, 1);

      // Back-to-back 3,5,7,9.
      t1 = '{4'd3, 4'd5, 4'd7, 4'd9};
      for (int i = 0; i < 4; i++) send(0, t1[i]);
      chk("t1_latency_valid", a_out_valid, 1);
      chk("t1_sum", a_out_sum, 24);
      chk("t1_hold_in_ready", a_in_ready, 0);
      tick();
      chk("t1_after_valid", a_out_valid, 0);
      chk("t1_after_in_ready", a_in_ready, 1);

      // Four 15s with 2-cycle gaps.
      for (int i = 0; i < 4; i++) begin
         send(0, 4'd15);
         if (i < 3) begin
            for (int g = 0; g < 2; g++) begin
               tick();
               chk("t2_gap_in_ready", a_in_ready, 1);
               chk("t2_gap_valid", a_out_valid, 0);
            end
         end
      end
      chk("t2_sum", a_out_sum, 60);
      chk("t2_hold_in_ready", a_in_ready, 0);
      tick();
      chk("t2_after_in_ready", a_in_ready, 1);

      // Backpressure: 1,2,3,4 with out_ready low for 5 cycles.
      a_out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(0, 4'(i));
      a_in_valid = 1'b1;
      a_in_op    = 4'd15;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_bp_valid", a_out_valid, 1);
         chk("t3_bp_sum", a_out_sum, 10);
         chk("t3_bp_in_ready", a_in_ready, 0);
      end
      a_in_valid = 1'b0;
      x0 = a_xfers;
      a_out_ready = 1'b1;
      tick();
      chk("t3_one_transfer", 32'(a_xfers - x0), 1);
      chk("t3_after_valid", a_out_valid, 0);
      tick();
      tick();
      chk("t3_sum_kept", a_out_sum, 10);
      chk("t3_no_extra_valid", a_out_valid, 0);

      // Reset mid-batch after 8,8.
      send(0, 4'd8);
      send(0, 4'd8);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t4_rst_valid", a_out_valid, 0);
      chk("t4_rst_sum", a_out_sum, 0);
      tick();
      rst_n = 1'b1;
      chk("t4_rel_in_ready", a_in_ready, 1);
      for (int i = 0; i < 4; i++) send(0, 4'd1);
      chk("t4_valid", a_out_valid, 1);
      chk("t4_sum", a_out_sum, 4);
      tick();

      // N_OPS=8: eight 15s wrap to 56, then eight 1s give 8.
      for (int i = 0; i < 8; i++) send(1, 4'd15);
      chk("t5_valid", b_out_valid, 1);
      chk("t5_sum", b_out_sum, 56);
`ifdef ACC_OVF_EN
      chk("t5_ovf", b_out_ovf, 1);
`endif
      tick();
      for (int i = 0; i < 8; i++) send(1, 4'd1);
      chk("t5b_sum", b_out_sum, 8);
`ifdef ACC_OVF_EN
      chk("t5b_ovf", b_out_ovf, 0);
`endif
      tick();

      // Random batches on both instances.
      for (int n = 0; n < 12; n++) send(0, 4'($urandom_range(0, 15)));
      for (int n = 0; n < 16; n++) send(1, 4'($urandom_range(0, 15)));
      tick();
      tick();
      tick();
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
